// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver: bclk-domain sampling into adc_clk, word framing, lock tracking
module i2s_rx #(
  parameter int sample_size  = 24,
  parameter int bclk_timeout = 1024
) (
  input  logic                   adc_clk,
  input  logic                   rst_n,
  input  logic                   i2s_bclk,
  input  logic                   i2s_wclk,
  input  logic                   i2s_sdata,
  output logic [sample_size-1:0] left_data,
  output logic [sample_size-1:0] right_data,
  output logic                   sample_valid,
  output logic                   frame_err,
  output logic                   locked
);

  localparam int CW = $clog2(sample_size + 2);
  localparam int TW = $clog2(bclk_timeout + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(sample_size);
  localparam logic [CW-1:0] CNT_SAT  = CW'(sample_size + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(bclk_timeout - 1);
  localparam logic [TW-1:0] TMO_SAT  = TW'(bclk_timeout);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  logic bclk_s1_q, bclk_s2_q, bclk_h_q;
  logic wclk_s1_q, wclk_s2_q;
  logic sdata_s1_q, sdata_s2_q;

  state_t                 state_q, state_d;
  logic [sample_size-1:0] shift_q, shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic                   wclk_prev_q, wclk_prev_d;
  logic                   wclk_seen_q, wclk_seen_d;
  logic [sample_size-1:0] left_stage_q, left_stage_d;
  logic                   left_vld_q, left_vld_d;
  logic [sample_size-1:0] left_data_q, left_data_d;
  logic [sample_size-1:0] right_data_q, right_data_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic                   rise;
  logic                   edge_rise;
  logic                   tmo_hit;
  logic [CW-1:0]          cnt_inc;
  logic [sample_size-1:0] word;

  // Identical two-flop synchronizers keep bclk, wclk and sdata aligned; bclk gets an extra history flop
  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      bclk_s1_q  <= 1'b0;
      bclk_s2_q  <= 1'b0;
      bclk_h_q   <= 1'b0;
      wclk_s1_q  <= 1'b0;
      wclk_s2_q  <= 1'b0;
      sdata_s1_q <= 1'b0;
      sdata_s2_q <= 1'b0;
    end else begin
      bclk_s1_q  <= i2s_bclk;
      bclk_s2_q  <= bclk_s1_q;
      bclk_h_q   <= bclk_s2_q;
      wclk_s1_q  <= i2s_wclk;
      wclk_s2_q  <= wclk_s1_q;
      sdata_s1_q <= i2s_sdata;
      sdata_s2_q <= sdata_s1_q;
    end
  end

  assign rise      = bclk_s2_q & ~bclk_h_q;
  // An edge needs a previously sampled wclk, so the first rise after reset or timeout only records it
  assign edge_rise = rise & wclk_seen_q & (wclk_s2_q != wclk_prev_q);
  assign tmo_hit   = ~rise & (tmo_cnt_q == TMO_LAST);
  assign cnt_inc   = (bit_cnt_q == CNT_SAT) ? CNT_SAT : bit_cnt_q + CW'(1);
  // The word closing on an edge rise already includes the LSB being sampled now
  assign word      = {shift_q[sample_size-2:0], sdata_s2_q};

  // Next-state logic: shifting and counting on every rise, framing decisions on edge rises, timeout
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    wclk_prev_d    = wclk_prev_q;
    wclk_seen_d    = wclk_seen_q;
    left_stage_d   = left_stage_q;
    left_vld_d     = left_vld_q;
    left_data_d    = left_data_q;
    right_data_d   = right_data_q;
    sample_valid_d = 1'b0;
    frame_err_d    = 1'b0;

    if (rise) begin
      shift_d     = word;
      bit_cnt_d   = cnt_inc;
      wclk_prev_d = wclk_s2_q;
      wclk_seen_d = 1'b1;
      tmo_cnt_d   = '0;
    end else if (tmo_cnt_q != TMO_SAT) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end

    case (state_q)
      HUNT: begin
        if (edge_rise) begin
          bit_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (edge_rise) begin
          bit_cnt_d = '0;
          if (cnt_inc == CNT_FULL) begin
            if (!wclk_prev_q) begin
              left_stage_d = word;
              left_vld_d   = 1'b1;
            end else if (left_vld_q) begin
              left_data_d    = left_stage_q;
              right_data_d   = word;
              sample_valid_d = 1'b1;
              left_vld_d     = 1'b0;
            end
          end else begin
            left_vld_d  = 1'b0;
            frame_err_d = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d     = HUNT;
          left_vld_d  = 1'b0;
          wclk_seen_d = 1'b0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      state_q        <= HUNT;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
      wclk_prev_q    <= 1'b0;
      wclk_seen_q    <= 1'b0;
      left_stage_q   <= '0;
      left_vld_q     <= 1'b0;
      left_data_q    <= '0;
      right_data_q   <= '0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      wclk_prev_q    <= wclk_prev_d;
      wclk_seen_q    <= wclk_seen_d;
      left_stage_q   <= left_stage_d;
      left_vld_q     <= left_vld_d;
      left_data_q    <= left_data_d;
      right_data_q   <= right_data_d;
      sample_valid_q <= sample_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign left_data    = left_data_q;
  assign right_data   = right_data_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;
  assign locked       = (state_q == RUN);

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed testbench for i2s_rx
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i2s_bclk;
  logic        i2s_wclk;
  logic        i2s_sdata;
  logic [23:0] left_data;
  logic [23:0] right_data;
  logic        sample_valid;
  logic        frame_err;
  logic        locked;

  int n_tests  = 0;
  int n_fail   = 0;
  int sv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int half     = 128;

  i2s_rx dut (
    .adc_clk      (clk),
    .rst_n        (rst_n),
    .i2s_bclk     (i2s_bclk),
    .i2s_wclk     (i2s_wclk),
    .i2s_sdata    (i2s_sdata),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .frame_err    (frame_err),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (sample_valid) sv_cnt++;
    if (frame_err) fe_cnt++;
    if (sample_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bclk period: data and wclk change with the falling edge, receiver samples on the rise
  task automatic send_bit(input logic w, input logic d);
    i2s_bclk  = 1'b0;
    i2s_wclk  = w;
    i2s_sdata = d;
    repeat (half) @(negedge clk);
    i2s_bclk = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // Standard I2S: wclk already shows the next channel while the LSB is on the line
  task automatic send_word(input logic ch, input logic [23:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--)
      send_bit((i == 0) ? ~ch : ch, v[i]);
  endtask

  initial begin
    int          sv0;
    int          fe0;
    int          fall_k;
    logic [23:0] rv;

    rst_n     = 1'b0;
    i2s_bclk  = 1'b0;
    i2s_wclk  = 1'b0;
    i2s_sdata = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_left", 32'(left_data), 32'h0);
    check("rst_right", 32'(right_data), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    rst_n = 1'b1;

    // Nominal stream at 256 adc_clk per bclk period
    half = 128;
    send_word(1'b0, 24'hA5A5A5, 24); #1;
    check("t1_lock", 32'(locked), 32'h1);
    send_word(1'b1, 24'h5A5A5A, 24); #1;
    check("t1_no_valid_first_pair", 32'(sv_cnt), 32'd0);
    send_word(1'b0, 24'hA5A5A5, 24);
    send_word(1'b1, 24'h5A5A5A, 24); #1;
    check("t1_valid_cnt1", 32'(sv_cnt), 32'd1);
    check("t1_left", 32'(left_data), 32'hA5A5A5);
    check("t1_right", 32'(right_data), 32'h5A5A5A);
    send_word(1'b0, 24'hA5A5A5, 24);
    send_word(1'b1, 24'h5A5A5A, 24); #1;
    check("t1_valid_cnt2", 32'(sv_cnt), 32'd2);
    check("t1_ferr", 32'(fe_cnt), 32'd0);

    // Short left slot
    half = 4;
    sv0 = sv_cnt;
    fe0 = fe_cnt;
    send_word(1'b0, 24'h2468AC, 23); #1;
    check("t2_ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
    send_word(1'b1, 24'h13579B, 24); #1;
    check("t2_right_dropped", 32'(sv_cnt - sv0), 32'd0);
    send_word(1'b0, 24'h111111, 24);
    send_word(1'b1, 24'h222222, 24); #1;
    check("t2_recover_cnt", 32'(sv_cnt - sv0), 32'd1);
    check("t2_recover_left", 32'(left_data), 32'h111111);
    check("t2_recover_right", 32'(right_data), 32'h222222);
    check("t2_ferr_once", 32'(fe_cnt - fe0), 32'd1);

    // Bit placement and strobe latency on the right LSB
    sv0 = sv_cnt;
    send_word(1'b0, 24'h800001, 24);
    for (int i = 23; i >= 1; i--) send_bit(1'b1, 1'b1);
    i2s_bclk  = 1'b0;
    i2s_wclk  = 1'b0;
    i2s_sdata = 1'b1;
    repeat (4) @(negedge clk);
    i2s_bclk = 1'b1;
    @(posedge clk); #1;
    check("t3_lat_cyc1", 32'(sample_valid), 32'h0);
    @(posedge clk); #1;
    check("t3_lat_cyc2", 32'(sample_valid), 32'h0);
    @(posedge clk); #1;
    check("t3_lat_cyc3", 32'(sample_valid), 32'h1);
    check("t3_left", 32'(left_data), 32'h800001);
    check("t3_right", 32'(right_data), 32'hFFFFFF);

    // bclk stops high: lock drops 1024 cycles after the rise was seen
    fall_k = 0;
    for (int k = 4; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (!locked && fall_k == 0) fall_k = k;
    end
    check("t4_lock_fall_cycle", 32'(fall_k), 32'd1027);
    check("t4_unlocked", 32'(locked), 32'h0);
    check("t4_hold_left", 32'(left_data), 32'h800001);
    check("t4_hold_right", 32'(right_data), 32'hFFFFFF);
    check("t4_one_valid", 32'(sv_cnt - sv0), 32'd1);
    sv0 = sv_cnt;
    send_word(1'b0, 24'h0F0F0F, 24); #1;
    check("t4_relock", 32'(locked), 32'h1);
    send_word(1'b1, 24'hF0F0F0, 24); #1;
    check("t4_no_valid_after_relock", 32'(sv_cnt - sv0), 32'd0);
    send_word(1'b0, 24'h123456, 24);
    send_word(1'b1, 24'h654321, 24); #1;
    check("t4_valid_cnt", 32'(sv_cnt - sv0), 32'd1);
    check("t4_left", 32'(left_data), 32'h123456);
    check("t4_right", 32'(right_data), 32'h654321);

    // One-cycle reset pulse while running
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_left", 32'(left_data), 32'h0);
    check("t6_right", 32'(right_data), 32'h0);
    check("t6_locked", 32'(locked), 32'h0);
    check("t6_valid", 32'(sample_valid), 32'h0);
    check("t6_ferr", 32'(frame_err), 32'h0);

    // Reset released in the middle of a right word
    rst_n = 1'b0;
    sv0 = sv_cnt;
    send_word(1'b0, 24'hABCDEF, 24); #1;
    check("t5_held_locked", 32'(locked), 32'h0);
    rv = 24'h13579B;
    for (int i = 23; i >= 1; i--) begin
      if (i == 13) rst_n = 1'b1;
      send_bit(1'b1, rv[i]);
    end
    #1;
    check("t5_prelock", 32'(locked), 32'h0);
    send_bit(1'b0, rv[0]); #1;
    check("t5_lock_on_edge", 32'(locked), 32'h1);
    check("t5_no_valid_edge", 32'(sv_cnt - sv0), 32'd0);
    send_word(1'b0, 24'h3C3C3C, 24); #1;
    check("t5_no_valid_left", 32'(sv_cnt - sv0), 32'd0);
    send_word(1'b1, 24'hC3C3C3, 24); #1;
    check("t5_valid_cnt", 32'(sv_cnt - sv0), 32'd1);
    check("t5_left", 32'(left_data), 32'h3C3C3C);
    check("t5_right", 32'(right_data), 32'hC3C3C3);

    check("no_overlap", 32'(both_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
